// File: rtl/tx_ten_eight.sv
// UART transmitter: start bit 0, 8 or 10 data bits LSB first, stop bit 1.
// Frame width and bit period are latched at frame acceptance, so the line stays stable mid-frame.
module tx_ten_eight (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [19:0] baud,
    input  logic        tx_en,
    input  logic        tx_start,
    input  logic [9:0]  tx_data,
    output logic        tx_out,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [3:0]  bit_cnt_out,
    output logic        baud_clk
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_n;
    logic [19:0] baud_cnt_q, baud_cnt_n;
    logic [19:0] baud_q, baud_n;
    logic [9:0]  shift_q, shift_n;
    logic        sel_q, sel_n;
    logic [3:0]  bit_cnt_n;
    logic [3:0]  n_bits;
    logic        tx_out_n, tx_busy_n, tx_done_n, baud_clk_n;
    logic        bit_end, last_data;

    always_comb begin
        state_n    = state_q;
        baud_cnt_n = baud_cnt_q;
        baud_n     = baud_q;
        shift_n    = shift_q;
        sel_n      = sel_q;
        bit_cnt_n  = bit_cnt_out;
        tx_out_n   = tx_out;
        tx_done_n  = 1'b0;
        n_bits     = sel_q ? 4'd10 : 4'd8;
        bit_end    = (baud_cnt_q == baud_q - 20'd1);
        last_data  = (bit_cnt_out == n_bits);

        case (state_q)
            IDLE: begin
                tx_out_n  = 1'b1;
                bit_cnt_n = 4'd0;
                if (tx_en && tx_start) begin
                    state_n    = START;
                    shift_n    = tx_data;
                    sel_n      = sel;
                    baud_n     = (baud < 20'd2) ? 20'd2 : baud;
                    baud_cnt_n = 20'd0;
                    tx_out_n   = 1'b0;
                end
            end
            default: begin
                if (bit_end) begin
                    baud_cnt_n = 20'd0;
                    bit_cnt_n  = bit_cnt_out + 4'd1;
                    case (state_q)
                        START: begin
                            state_n  = DATA;
                            tx_out_n = shift_q[0];
                            shift_n  = {1'b0, shift_q[9:1]};
                        end
                        DATA: begin
                            if (last_data) begin
                                state_n  = STOP;
                                tx_out_n = 1'b1;
                            end else begin
                                tx_out_n = shift_q[0];
                                shift_n  = {1'b0, shift_q[9:1]};
                            end
                        end
                        default: begin
                            state_n   = IDLE;
                            tx_out_n  = 1'b1;
                            tx_done_n = 1'b1;
                            bit_cnt_n = 4'd0;
                        end
                    endcase
                end else begin
                    baud_cnt_n = baud_cnt_q + 20'd1;
                end
            end
        endcase

        // Outputs are registered, so they are derived from the next-cycle state and count.
        tx_busy_n  = (state_n != IDLE);
        baud_clk_n = (state_n != IDLE) && (baud_cnt_n == baud_n - 20'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            baud_cnt_q  <= 20'd0;
            baud_q      <= 20'd2;
            sel_q       <= 1'b0;
            bit_cnt_out <= 4'd0;
            tx_out      <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
            baud_clk    <= 1'b0;
        end else begin
            state_q     <= state_n;
            baud_cnt_q  <= baud_cnt_n;
            baud_q      <= baud_n;
            sel_q       <= sel_n;
            bit_cnt_out <= bit_cnt_n;
            tx_out      <= tx_out_n;
            tx_busy     <= tx_busy_n;
            tx_done     <= tx_done_n;
            baud_clk    <= baud_clk_n;
        end
    end

    // Data shadow carries no control meaning, so it is left out of reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_n;
    end

endmodule

// File: tb/tb_tx_ten_eight.sv
// Directed bench for tx_ten_eight: expected frames are queued at send time and
// checked cycle by cycle by a line monitor that decodes the serial output.
module tb_tx_ten_eight;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [19:0] baud = 20'd2;
    logic        tx_en = 1'b0;
    logic        tx_start = 1'b0;
    logic [9:0]  tx_data = 10'd0;
    logic        tx_out, tx_busy, tx_done, baud_clk;
    logic [3:0]  bit_cnt_out;

    tx_ten_eight dut (
        .clk(clk), .rst(rst), .sel(sel), .baud(baud), .tx_en(tx_en),
        .tx_start(tx_start), .tx_data(tx_data), .tx_out(tx_out),
        .tx_busy(tx_busy), .tx_done(tx_done), .bit_cnt_out(bit_cnt_out),
        .baud_clk(baud_clk)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] data;
        int         n;
        int         b;
    } frame_t;

    frame_t exp_q[$];
    int     gaps[$];
    int     tests = 0;
    int     fails = 0;
    int     frames_done = 0;
    int     done_cnt = 0;

    task automatic check(string tag, int obs, int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void expect_frame(logic [9:0] d, logic s, logic [19:0] b);
        frame_t f;
        f.n    = s ? 10 : 8;
        f.b    = (b < 2) ? 2 : int'(b);
        f.data = s ? d : {2'b00, d[7:0]};
        exp_q.push_back(f);
    endfunction

    // Line monitor: pops the expected frame when tx_busy rises and checks every busy cycle.
    frame_t cur;
    logic   in_frame = 1'b0;
    int     cyc, mism, bclk, idle_run = 0;
    always @(negedge clk) begin
        int   idx;
        logic eb;
        if (rst) begin
            in_frame = 1'b0;
            idle_run = 0;
        end else begin
            if (tx_done) done_cnt++;
            if (tx_busy) begin
                if (!in_frame) begin
                    gaps.push_back(idle_run);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        in_frame = 1'b1;
                        cyc = 0; mism = 0; bclk = 0;
                    end
                end
                if (in_frame) begin
                    idx = cyc / cur.b;
                    if (idx == 0)          eb = 1'b0;
                    else if (idx <= cur.n) eb = cur.data[idx-1];
                    else                   eb = 1'b1;
                    if (tx_out !== eb || int'(bit_cnt_out) != idx ||
                        baud_clk !== ((cyc % cur.b) == cur.b - 1))
                        mism++;
                    if (baud_clk) bclk++;
                    cyc++;
                end
                idle_run = 0;
            end else begin
                if (in_frame) begin
                    check("frame_bits_mismatches", mism, 0);
                    check("frame_busy_cycles", cyc, (cur.n + 2) * cur.b);
                    check("frame_baud_clk_pulses", bclk, cur.n + 2);
                    check("frame_done_pulse", tx_done, 1);
                    check("frame_end_line", tx_out, 1);
                    in_frame = 1'b0;
                    frames_done++;
                end
                idle_run++;
            end
        end
    end

    task automatic send(logic [9:0] d, logic s, logic [19:0] b);
        tx_data  = d;
        sel      = s;
        baud     = b;
        tx_en    = 1'b1;
        tx_start = 1'b1;
        expect_frame(d, s, b);
        @(negedge clk); #1;
        check("accept_busy", tx_busy, 1);
        check("accept_line", tx_out, 0);
        tx_start = 1'b0;
    endtask

    task automatic wait_frames(int target, int budget);
        int k = 0;
        while (frames_done < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("frames_done", frames_done, target);
    endtask

    initial begin
        int   bad;
        int   base;
        int   k;
        int   dc;
        logic s;
        logic [9:0] d;

        // Reset and idle with tx_en low
        repeat (2) @(negedge clk);
        #1;
        check("rst_tx_out", tx_out, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_bit_cnt", bit_cnt_out, 0);
        check("rst_done", tx_done, 0);
        check("rst_baud_clk", baud_clk, 0);
        rst = 1'b0; tx_en = 1'b0; tx_start = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk); #1;
            if (tx_out !== 1'b1 || tx_busy !== 1'b0 || bit_cnt_out !== 4'd0 || tx_done !== 1'b0)
                bad++;
        end
        tx_start = 1'b0;
        check("idle_disabled_bad_cycles", bad, 0);
        check("idle_disabled_frames", frames_done, 0);
        check("idle_disabled_done", done_cnt, 0);

        // 10-bit frame, 20 cycles per bit
        send(10'b00101_11011, 1'b1, 20'd20);
        wait_frames(1, 300);

        // 8-bit frame, upper bits ignored
        send(10'h3A5, 1'b0, 20'd3);
        wait_frames(2, 60);

        // baud 0 and 1 behave as 2
        send(10'h05A, 1'b0, 20'd0);
        wait_frames(3, 60);
        send(10'h2C3, 1'b1, 20'd1);
        wait_frames(4, 60);

        // Mid-frame start pulse and input changes are ignored
        send(10'h1E7, 1'b1, 20'd4);
        repeat (10) @(negedge clk);
        #1;
        tx_start = 1'b1; baud = 20'd7; tx_data = 10'h018; sel = 1'b0;
        @(negedge clk); #1;
        tx_start = 1'b0;
        wait_frames(5, 100);
        repeat (20) @(negedge clk);
        #1;
        check("guard_no_second_frame", frames_done, 5);
        check("guard_queue_empty", exp_q.size(), 0);

        // tx_start held high: one idle cycle between frames
        base = frames_done;
        sel = 1'b0; baud = 20'd2; tx_data = 10'h05C; tx_en = 1'b1;
        repeat (3) expect_frame(10'h05C, 1'b0, 20'd2);
        gaps.delete();
        tx_start = 1'b1;
        k = 0;
        while (frames_done < base + 3 && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        tx_start = 1'b0;
        check("held_frames", frames_done, base + 3);
        check("held_gap_count", gaps.size(), 3);
        if (gaps.size() == 3) begin
            check("held_gap_1", gaps[1], 1);
            check("held_gap_2", gaps[2], 1);
        end
        repeat (10) @(negedge clk);
        #1;
        check("held_no_extra_frame", frames_done, base + 3);

        // Reset during data bit 4
        base = frames_done;
        dc = done_cnt;
        send(10'h2B6, 1'b1, 20'd5);
        k = 0;
        while (bit_cnt_out != 4'd5 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check("rst_mid_reached_bit", bit_cnt_out, 5);
        rst = 1'b1;
        @(negedge clk); #1;
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_line", tx_out, 1);
        check("rst_mid_done", tx_done, 0);
        check("rst_mid_bit_cnt", bit_cnt_out, 0);
        rst = 1'b0;
        check("rst_mid_no_done", done_cnt, dc);
        check("rst_mid_not_completed", frames_done, base);
        send(10'h0F1, 1'b0, 20'd5);
        wait_frames(base + 1, 100);

        // Random words, random width, 20 cycles per bit
        for (int i = 0; i < 50; i++) begin
            base = frames_done;
            s = 1'($urandom_range(0, 1));
            d = 10'($urandom);
            send(d, s, 20'd20);
            wait_frames(base + 1, 300);
        end
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tx_ten_eight.md
# tx_ten_eight

UART transmitter that serialises one 8-bit or 10-bit data word per frame onto a single line: start bit 0, data LSB first, stop bit 1. It sits directly upstream of `rx_ten_eight` and shares its `sel`/`baud` conventions, so `tx_out` can drive `rx_in` directly for loopback. Bit timing is a programmable clock-cycles-per-bit divisor. A start/busy/done handshake faces the host.

## Interface
- No parameters; frame format is selected at run time by `sel`.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sel` input 1: frame width; 1 = 10 data bits (`tx_data[9:0]`), 0 = 8 data bits (`tx_data[7:0]`).
- `baud` input 20: clock cycles per bit; values 0 and 1 are treated as 2.
- `tx_en` input 1: transmitter enable; gates frame acceptance only.
- `tx_start` input 1: request to send `tx_data`; level-sampled.
- `tx_data` input 10: word to send; bits [9:8] ignored when `sel`=0.
- `tx_out` output 1: serial line; idles high.
- `tx_busy` output 1: high from frame acceptance through the last stop-bit cycle.
- `tx_done` output 1: one-cycle pulse at frame end.
- `bit_cnt_out` output 4: frame bit index being driven; 0 = start bit, 1..N = data bits, N+1 = stop bit. Held 0 in IDLE.
- `baud_clk` output 1: one-cycle pulse on the last cycle of each bit period; 0 when idle.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `tx_out`=1, `tx_busy`=0.
  - If `tx_en`=1 and `tx_start`=1 at an edge: latch `tx_data`, `sel`, and `baud` (clamped to at least 2) into shadow registers, then go to START.
- START: drive 0 for one bit period, then go to DATA.
- DATA:
  - Drive shadow bit k on data bit k+1 (k = 0..N-1, LSB first). N = 10 if the latched `sel`=1, otherwise 8.
  - After bit N-1, go to STOP.
- STOP: drive 1 for one bit period, then go to IDLE and pulse `tx_done`.
- Baud counter: 20 bits, counts 0..B-1 within each bit (B = latched baud) and resets to 0 at each bit boundary. `baud_clk`=1 when count==B-1 and the state is not IDLE.
- `bit_cnt_out` increments at each bit boundary.
- Input handling:
  - Changes to `sel`, `baud`, or `tx_data` while busy have no effect on the frame in progress.
  - `tx_start` while busy is ignored; it is not queued.
  - `tx_en` deasserted mid-frame does not abort; the frame completes.
  - `tx_en`=0 in IDLE: `tx_start` is ignored.

## Timing
- Reset values (the edge after `rst`=1): state IDLE, `tx_out`=1, `tx_busy`=0, `tx_done`=0, `bit_cnt_out`=0, `baud_clk`=0, all counters 0.
- Reset overrides everything, including mid-frame; the line returns high at the next edge and the frame is not completed.
- All outputs are registered.
- Frame acceptance (accepting edge E):
  - `tx_out` falls and `tx_busy` rises right after E.
  - Start bit occupies cycles E..E+B-1.
- Frame length: exactly (N+2)·B cycles of `tx_busy`=1. For example: 12·B with `sel`=1, 10·B with `sel`=0.
- Frame end:
  - At the edge ending the stop bit, `tx_busy` falls and `tx_done`=1 for one cycle, with `tx_out`=1.
  - `tx_start` held high during the `tx_done` cycle is accepted at the next edge.
  - Back-to-back frames therefore have a minimum of 1 extra idle-high cycle between stop and start.
- `baud_clk` pulses exactly N+2 times per frame.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst` for 2 cycles, then `tx_en`=0 with `tx_start`=1 for 10 cycles.
  - Required: `tx_out`=1, `tx_busy`=0, `bit_cnt_out`=0, and no `tx_done` throughout.
- 10-bit frame:
  - Stimulus: `baud`=20, `sel`=1, `tx_data`=10'b00101_11011, start pulse.
  - Required `tx_out` sequence (20 cycles each): 0, 1,1,0,1,1,1,0,1,0,0, 1.
  - Required: `tx_busy` high for 240 cycles, one `tx_done` pulse, 12 `baud_clk` pulses.
- 8-bit frame and width rules:
  - Stimulus: `baud`=3, `sel`=0, `tx_data`=10'h3A5.
  - Required: line sends 8'hA5 LSB first (1,0,1,0,0,1,0,1) between start and stop, with upper bits ignored; `tx_busy` high for 30 cycles.
- Guarding:
  - Stimulus: `baud`=0. Required: 2-cycle bits.
  - Stimulus: pulse `tx_start` mid-frame, and change `baud`/`tx_data` mid-frame. Required: frame unchanged, no second frame.
  - Stimulus: hold `tx_start` high continuously. Required: frames separated by exactly one idle cycle.
- Reset mid-frame:
  - Stimulus: assert `rst` during data bit 4.
  - Required: `tx_out`=1 and `tx_busy`=0 the next cycle, no `tx_done`; a new frame afterwards transmits correctly.
- Loopback:
  - Stimulus: `tx_out` connected to `rx_ten_eight` `rx_in`, matching `sel`/`baud`=20, random words.
  - Required: received 10-bit or 8-bit data equals `tx_data` for 50 consecutive frames.
